// File: rtl/sprite_line_sched.sv
// rtl/sprite_line_sched.sv - per-scanline sprite selection and per-pixel ROM address resolution
//
// Purpose: during hblank, scan the live object table and pick up to MAX_PER_LINE
// sprites that intersect the next scanline into a back slot bank. During the
// active line, resolve the covering sprite per pixel from the front bank by
// fixed priority (lowest slot wins).
//
// Ports:
//   vga_clk, reset_n          pixel clock, synchronous active-low reset
//   DrawX, DrawY, blank       current pixel position and visible flag (blank=1 visible)
//   cfg_we, cfg_idx, cfg_en,
//   cfg_x, cfg_y              object table write port (shadow table)
//   hit, rom_sel, rom_address registered per-pixel result, 1-cycle latency
//   line_overflow             sticky: a line had more than MAX_PER_LINE sprites
module sprite_line_sched #(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int SPR_W        = 20,
  parameter int SPR_H        = 20,
  parameter int ROM_AW       = 9,
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int CW = $clog2(MAX_PER_LINE + 1)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic              cfg_en,
  input  logic [9:0]        cfg_x,
  input  logic [9:0]        cfg_y,
  output logic              hit,
  output logic [IW-1:0]     rom_sel,
  output logic [ROM_AW-1:0] rom_address,
  output logic              line_overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t state_q, state_d;

  // Object tables: shadow takes config writes, live is what the scanner reads.
  logic       sh_en [NUM_SPRITES];
  logic [9:0] sh_x  [NUM_SPRITES];
  logic [9:0] sh_y  [NUM_SPRITES];
  logic       lv_en [NUM_SPRITES];
  logic [9:0] lv_x  [NUM_SPRITES];
  logic [9:0] lv_y  [NUM_SPRITES];

  // Double-buffered slot banks: [front] is displayed, [back] is being filled.
  logic          slot_v   [2][MAX_PER_LINE];
  logic [IW-1:0] slot_idx [2][MAX_PER_LINE];
  logic [9:0]    slot_x   [2][MAX_PER_LINE];
  logic [9:0]    slot_row [2][MAX_PER_LINE];
  logic          front;
  logic          back;

  logic [9:0]    ny;
  logic [IW-1:0] scan_i;
  logic [CW-1:0] count;

  logic          commit;
  logic          scan_last;
  logic          scan_hit;
  logic [9:0]    scan_row;

  logic          found;
  logic [IW-1:0] win_idx;
  logic [9:0]    win_dx;
  logic [9:0]    win_row;

  assign back      = ~front;
  assign commit    = (DrawY == 10'd480) && (DrawX == 10'd0);
  assign scan_last = (scan_i == IW'(NUM_SPRITES - 1));

  // Row test done at 11 bits so y+SPR_H-1 never wraps past 1023.
  always_comb begin
    scan_hit = lv_en[scan_i]
            && ({1'b0, ny} >= {1'b0, lv_y[scan_i]})
            && ({1'b0, ny} <= ({1'b0, lv_y[scan_i]} + 11'(SPR_H - 1)));
    scan_row = ny - lv_y[scan_i];
  end

  // Descending walk so the lowest covering slot is the one left standing.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_dx  = '0;
    win_row = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      if (slot_v[front][s]
          && ({1'b0, DrawX} >= {1'b0, slot_x[front][s]})
          && ({1'b0, DrawX} <= ({1'b0, slot_x[front][s]} + 11'(SPR_W - 1)))) begin
        found   = 1'b1;
        win_idx = slot_idx[front][s];
        win_dx  = DrawX - slot_x[front][s];
        win_row = slot_row[front][s];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (DrawX == 10'd640) state_d = SCAN;
      SCAN:    if (scan_last)        state_d = READY;
      READY:   if (DrawX == 10'd799) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_en[i] <= 1'b0;
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        lv_en[i] <= 1'b0;
        lv_x[i]  <= '0;
        lv_y[i]  <= '0;
      end
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < MAX_PER_LINE; s++) begin
          slot_v[b][s]   <= 1'b0;
          slot_idx[b][s] <= '0;
          slot_x[b][s]   <= '0;
          slot_row[b][s] <= '0;
        end
      end
      front         <= 1'b0;
      ny            <= '0;
      scan_i        <= '0;
      count         <= '0;
      hit           <= 1'b0;
      rom_sel       <= '0;
      rom_address   <= '0;
      line_overflow <= 1'b0;
    end else begin
      if (cfg_we) begin
        sh_en[cfg_idx] <= cfg_en;
        sh_x[cfg_idx]  <= cfg_x;
        sh_y[cfg_idx]  <= cfg_y;
      end

      // A write landing on the commit cycle is forwarded straight into live.
      if (commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (cfg_we && (cfg_idx == IW'(i))) begin
            lv_en[i] <= cfg_en;
            lv_x[i]  <= cfg_x;
            lv_y[i]  <= cfg_y;
          end else begin
            lv_en[i] <= sh_en[i];
            lv_x[i]  <= sh_x[i];
            lv_y[i]  <= sh_y[i];
          end
        end
        line_overflow <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (DrawX == 10'd640) begin
            ny     <= (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
            scan_i <= '0;
            count  <= '0;
            for (int s = 0; s < MAX_PER_LINE; s++) slot_v[back][s] <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            if (int'(count) < MAX_PER_LINE) begin
              for (int s = 0; s < MAX_PER_LINE; s++) begin
                if (count == CW'(s)) begin
                  slot_v[back][s]   <= 1'b1;
                  slot_idx[back][s] <= scan_i;
                  slot_x[back][s]   <= lv_x[scan_i];
                  slot_row[back][s] <= scan_row;
                end
              end
              count <= count + CW'(1);
            end else begin
              line_overflow <= 1'b1;
            end
          end
          scan_i <= scan_i + IW'(1);
        end
        READY: begin
          if (DrawX == 10'd799) front <= ~front;
        end
        default: ;
      endcase

      if (blank && found) begin
        hit         <= 1'b1;
        rom_sel     <= win_idx;
        rom_address <= ROM_AW'(win_dx) + ROM_AW'(win_row) * ROM_AW'(SPR_W);
      end else begin
        hit         <= 1'b0;
        rom_sel     <= '0;
        rom_address <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_sched.sv
// tb/tb_sprite_line_sched.sv - self-checking bench for sprite_line_sched
module tb_sprite_line_sched;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic       cfg_en;
  logic [9:0] cfg_x, cfg_y;
  logic       hit;
  logic [2:0] rom_sel;
  logic [8:0] rom_address;
  logic       line_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int line;
    int px;
    int blk;
    int e_hit;
    int e_sel;
    int e_addr;
  } vec_t;

  vec_t vt[$];

  sprite_line_sched dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_en        (cfg_en),
    .cfg_x         (cfg_x),
    .cfg_y         (cfg_y),
    .hit           (hit),
    .rom_sel       (rom_sel),
    .rom_address   (rom_address),
    .line_overflow (line_overflow)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_px(input string name, input int e_hit, input int e_sel, input int e_addr);
    check({name, ".hit"},  int'(hit),         e_hit);
    check({name, ".sel"},  int'(rom_sel),     e_sel);
    check({name, ".addr"}, int'(rom_address), e_addr);
  endtask

  task automatic cfg_write(input int idx, input int en, input int x, input int y);
    cfg_idx = 3'(idx);
    cfg_en  = en[0];
    cfg_x   = 10'(x);
    cfg_y   = 10'(y);
    cfg_we  = 1'b1;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic commit();
    DrawY = 10'd480;
    DrawX = 10'd0;
    tick();
    DrawX = 10'd1;
  endtask

  // Run one hblank scan for line n, then swap banks so line n is displayed.
  task automatic prep_line(input int n);
    blank = 1'b0;
    DrawY = (n == 0) ? 10'd524 : 10'(n - 1);
    DrawX = 10'd640;
    tick();
    for (int k = 641; k <= 650; k++) begin
      DrawX = 10'(k);
      tick();
    end
    DrawX = 10'd799;
    tick();
    DrawX = 10'd1;
  endtask

  task automatic pixel(input int line, input int x, input int blk);
    DrawY = 10'(line);
    DrawX = 10'(x);
    blank = blk[0];
    tick();
  endtask

  initial begin
    int cur_line;
    reset_n = 1'b0;
    DrawX = 10'd1;
    DrawY = 10'd0;
    blank = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_en = 1'b0;
    cfg_x = '0;
    cfg_y = '0;
    tick();
    tick();
    check_px("reset", 0, 0, 0);
    check("reset.ovf", int'(line_overflow), 0);
    reset_n = 1'b1;
    tick();

    // Single sprite, edges, blank gating and line-0 wrap.
    cfg_write(2, 1, 100, 50);
    cfg_write(5, 1, 300, 0);
    commit();

    vt.push_back('{55, 105, 1, 1, 2, 105});
    vt.push_back('{55,  99, 1, 0, 0,   0});
    vt.push_back('{55, 100, 1, 1, 2, 100});
    vt.push_back('{55, 105, 0, 0, 0,   0});
    vt.push_back('{69, 119, 1, 1, 2, 399});
    vt.push_back('{69, 120, 1, 0, 0,   0});
    vt.push_back('{50, 100, 1, 1, 2,   0});
    vt.push_back('{70, 110, 1, 0, 0,   0});
    vt.push_back('{49, 110, 1, 0, 0,   0});
    vt.push_back('{ 0, 300, 1, 1, 5,   0});
    vt.push_back('{ 0, 319, 1, 1, 5,  19});
    vt.push_back('{ 0, 310, 0, 0, 0,   0});
    vt.push_back('{19, 305, 1, 1, 5, 385});
    vt.push_back('{20, 305, 1, 0, 0,   0});

    cur_line = -1;
    foreach (vt[i]) begin
      if (vt[i].line != cur_line) begin
        prep_line(vt[i].line);
        cur_line = vt[i].line;
      end
      pixel(vt[i].line, vt[i].px, vt[i].blk);
      check_px($sformatf("vec%0d", i), vt[i].e_hit, vt[i].e_sel, vt[i].e_addr);
    end
    check("vec.ovf", int'(line_overflow), 0);

    // Priority: sprites 1, 2, 3 overlap; lowest index wins.
    cfg_write(1, 1, 100, 50);
    cfg_write(3, 1, 100, 50);
    commit();
    prep_line(55);
    pixel(55, 105, 1);
    check_px("prio", 1, 1, 105);

    // Move mid-frame: live position holds until the next commit.
    cfg_write(1, 1, 400, 50);
    prep_line(55);
    pixel(55, 105, 1);
    check_px("move.old", 1, 1, 105);
    pixel(55, 405, 1);
    check_px("move.new_early", 0, 0, 0);

    // Commit with a simultaneous write (write-then-copy).
    cfg_idx = 3'd6;
    cfg_en = 1'b1;
    cfg_x = 10'd500;
    cfg_y = 10'd60;
    cfg_we = 1'b1;
    commit();
    cfg_we = 1'b0;
    prep_line(60);
    pixel(60, 105, 1);
    check_px("move.after2", 1, 2, 205);
    pixel(60, 405, 1);
    check_px("move.after1", 1, 1, 205);
    pixel(60, 510, 1);
    check_px("wtc", 1, 6, 10);

    // Overflow: 5 sprites on the same rows, slot limit 4.
    for (int i = 0; i < 8; i++) cfg_write(i, 0, 0, 0);
    for (int i = 0; i < 5; i++) cfg_write(i, 1, 30 * i, 10);
    commit();
    check("ovf.pre", int'(line_overflow), 0);
    prep_line(15);
    check("ovf.set", int'(line_overflow), 1);
    pixel(15, 125, 1);
    check_px("ovf.spr4", 0, 0, 0);
    pixel(15, 100, 1);
    check_px("ovf.spr3", 1, 3, 110);
    pixel(15, 5, 1);
    check_px("ovf.spr0", 1, 0, 105);
    prep_line(10);
    pixel(10, 130, 1);
    check_px("ovf.l10", 0, 0, 0);
    prep_line(29);
    pixel(29, 139, 1);
    check_px("ovf.l29", 0, 0, 0);
    pixel(29, 109, 1);
    check_px("ovf.l29s3", 1, 3, 399);
    check("ovf.sticky", int'(line_overflow), 1);
    commit();
    check("ovf.clr", int'(line_overflow), 0);

    // Reset in the middle of a scan.
    prep_line(15);
    check("rst.ovf_pre", int'(line_overflow), 1);
    DrawY = 10'd14;
    DrawX = 10'd640;
    tick();
    DrawX = 10'd641;
    tick();
    DrawX = 10'd642;
    blank = 1'b1;
    tick();
    reset_n = 1'b0;
    DrawX = 10'd5;
    DrawY = 10'd15;
    tick();
    check_px("rst.mid", 0, 0, 0);
    check("rst.ovf", int'(line_overflow), 0);
    reset_n = 1'b1;
    DrawX = 10'd799;
    blank = 1'b0;
    tick();
    pixel(15, 5, 1);
    check_px("rst.after", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_sched.md
# sprite_line_sched

Per-scanline sprite scheduler for the VGA pixel pipeline. During horizontal blanking it scans the sprite object table and selects up to `MAX_PER_LINE` sprites that intersect the next scanline. During the active line it resolves, per pixel, which sprite covers `DrawX`/`DrawY` by fixed priority. It then drives the shared sprite ROM address, bank select and hit flag consumed by the downstream ROM/palette renderer.

## Interface

**Parameters**
- `NUM_SPRITES`, 8: entries in the object table (power of 2).
- `MAX_PER_LINE`, 4: sprite slots per scanline.
- `SPR_W`, 20: sprite width in pixels.
- `SPR_H`, 20: sprite height in pixels.
- `ROM_AW`, 9: ROM address width; must satisfy `SPR_W*SPR_H <= 2**ROM_AW`.

**Ports** (clock and reset first)
- `vga_clk`, in, 1: pixel clock; the only clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `DrawX`, in, 10: current pixel column, 0..799.
- `DrawY`, in, 10: current scanline, 0..524.
- `blank`, in, 1: 1 = visible region.
- `cfg_we`, in, 1: object table write strobe.
- `cfg_idx`, in, log2(NUM_SPRITES): entry to write.
- `cfg_en`, in, 1: entry enable.
- `cfg_x`, in, 10: entry top-left X.
- `cfg_y`, in, 10: entry top-left Y.
- `hit`, out, 1: current pixel is covered by a sprite.
- `rom_sel`, out, log2(NUM_SPRITES): winning sprite index, selects the ROM bank.
- `rom_address`, out, ROM_AW: `DistX + DistY*SPR_W` of the winner.
- `line_overflow`, out, 1: sticky; set when more than `MAX_PER_LINE` sprites hit a line.

## Operation

- **Table**
  - Config writes go to a shadow table.
  - The shadow table commits to the live table in the single cycle where `DrawY==480 && DrawX==0`.
  - A write in that same cycle is committed as well: write-then-copy.
- **FSM states:** IDLE, SCAN, READY.
- **IDLE**
  - On `DrawX==640`, latch `NY` = (`DrawY==524`) ? 0 : `DrawY+1`.
  - Clear the back slot bank and go to SCAN.
- **SCAN**
  - Visits entry `i = 0..NUM_SPRITES-1`, one per cycle, in ascending order.
  - An entry hits when `en && NY >= y && NY <= y+SPR_H-1`, with comparison at 11 bits (no wrap).
  - On a hit: if `count < MAX_PER_LINE`, store `{i, x, NY-y}` in back slot `count` and increment `count`. Otherwise set `line_overflow`.
  - After entry `NUM_SPRITES-1`, go to READY.
- **READY**
  - On `DrawX==799`, swap the front and back banks and go to IDLE.
  - SCAN always completes well before `DrawX==799` (8 cycles vs 159).
- **Per-pixel resolution (front bank)**
  - Slot `s` covers the pixel when `valid && DrawX >= x && DrawX <= x+SPR_W-1`, with comparison at 11 bits.
  - The lowest slot index wins, which is equivalent to the lowest sprite index.
  - `DistX = DrawX - x`. `DistY` is the stored row.
  - `rom_address = DistX + DistY*SPR_W`, truncated to `ROM_AW`.
- **Output gating:** when `blank==0` or no slot covers the pixel, drive `hit=0`, `rom_sel=0`, `rom_address=0`.
- **`line_overflow`:** cleared only at the table commit point (`DrawY==480, DrawX==0`) or by reset.

## Timing

- **Registered outputs:** all outputs are registered on posedge `vga_clk`.
- **Latency:** 1 cycle from `DrawX`/`DrawY`/`blank` to `hit`/`rom_sel`/`rom_address`.
- **Line selection:** sprites shown on line N were selected during hblank of line N-1. Line 0 is selected during line 524.
- **Reset (`reset_n==0` at posedge)**
  - Outputs: `hit=0`, `rom_sel=0`, `rom_address=0`, `line_overflow=0`.
  - Shadow and live tables are all disabled.
  - Both slot banks are invalid.
  - FSM enters IDLE.
- **Reset mid-SCAN:** the partial scan is discarded. The next line shows no sprites until the following hblank scan.
- **Config write during SCAN:** has no effect on the current frame, because it only affects the shadow table.

## Test plan

- **Single sprite, interior pixel:**
  - Setup: reset, write idx 2 `{en=1, x=100, y=50}`, advance past line 480.
  - Stimulus: at line 55, X=105, `blank=1`.
  - Required, 1 cycle later: `hit=1`, `rom_sel=2`, `rom_address=5+5*20=105`.
- **Edge inclusivity:**
  - Same sprite as above, line 69.
  - Stimulus: X=119, then X=120.
  - Required: `rom_address=19+19*20=399`, then `hit=0`.
- **Priority:**
  - Setup: sprites 1 and 3 both at `{100,50}`.
  - Stimulus: any covered pixel.
  - Required: `rom_sel=1`.
- **Overflow:**
  - Setup: 5 sprites enabled at `y=10`, x spaced by 30.
  - Required: sprite 4 is never hit on lines 10..29, and `line_overflow=1`. `line_overflow` clears at the next `DrawY==480, DrawX==0`.
- **Wrap and blank:**
  - Setup: sprite at `y=0`.
  - Required: covers line 0, selected during line 524. `hit=0` whenever `blank=0`.
- **Commit timing and reset mid-operation:**
  - Stimulus: move a sprite mid-frame.
  - Required: position is unchanged until the next frame.
  - Stimulus: assert `reset_n=0` for 1 cycle during SCAN.
  - Required: all outputs are 0 and no sprite is shown afterwards.
